// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch-stage types: NOP encoding, fetch FSM states, buffer entry layout
package if_stage_pkg;

   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      SQUASH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// rtl/if_stage_fetch_buffer.sv - small synchronous FIFO holding fetched {pc, inst} entries
module if_stage_fetch_buffer #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [63:0]                wr_data,
   output logic [63:0]                rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));

   // Storage is not reset; only pointers and occupancy need a defined state.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, one-at-a-time imem requests, fetch buffer, IF/ID register
// Optional IF_BYPASS_EN: a response arriving with the buffer empty and no stall goes straight into IF/ID.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INST  = DEFAULT_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        take_branch,
   input  logic [31:0] target_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_IR,
   output logic [31:0] if_id_PC,
   output logic [31:0] if_id_NPC,
   output logic        if_id_valid_inst
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic          empty;
   logic          full;
   logic          slot_free;
   logic          rsp_accept;
   logic          bypass;
   logic          buf_push;
   logic          buf_pop;
   logic [63:0]   buf_rd_data;
   fetch_entry_t  head;

   assign outstanding = (state == FETCH) ? '0 : CW'(1);
   assign slot_free   = !full && ((count + outstanding) < CW'(BUF_DEPTH));
   assign imem_req    = !rst && (state == FETCH) && slot_free && !take_branch;
   assign imem_addr   = pc;

   assign rsp_accept  = (state == WAIT) && imem_rvalid && !take_branch;
`ifdef IF_BYPASS_EN
   assign bypass      = rsp_accept && empty && !stall;
`else
   assign bypass      = 1'b0;
`endif
   assign buf_push    = rsp_accept && !bypass;
   assign buf_pop     = !take_branch && !stall && !empty;
   assign head        = buf_rd_data;

   if_stage_fetch_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_fetch_buffer (
      .clk     (clk),
      .rst     (rst),
      .push    (buf_push),
      .pop     (buf_pop),
      .flush   (take_branch),
      .wr_data ({req_pc, imem_rdata}),
      .rd_data (buf_rd_data),
      .count   (count),
      .empty   (empty),
      .full    (full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else if (take_branch) begin
         pc <= {target_pc[31:2], 2'b00};
         // A response landing in the redirect cycle is dropped and closes the transaction.
         case (state)
            WAIT:    state <= imem_rvalid ? FETCH : SQUASH;
            SQUASH:  state <= imem_rvalid ? FETCH : SQUASH;
            default: state <= FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (imem_req) begin
                  pc     <= pc + 32'd4;
                  req_pc <= pc;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state <= FETCH;
               end
            end
            SQUASH: begin
               if (imem_rvalid) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_IR         <= NOP_INST;
         if_id_PC         <= 32'h0000_0000;
         if_id_NPC        <= 32'h0000_0004;
         if_id_valid_inst <= 1'b0;
      end else if (take_branch) begin
         if_id_IR         <= NOP_INST;
         if_id_valid_inst <= 1'b0;
      end else if (!stall) begin
         if (bypass) begin
            if_id_IR         <= imem_rdata;
            if_id_PC         <= req_pc;
            if_id_NPC        <= req_pc + 32'd4;
            if_id_valid_inst <= 1'b1;
         end else if (!empty) begin
            if_id_IR         <= head.inst;
            if_id_PC         <= head.pc;
            if_id_NPC        <= head.pc + 32'd4;
            if_id_valid_inst <= 1'b1;
         end else begin
            if_id_IR         <= NOP_INST;
            if_id_valid_inst <= 1'b0;
         end
      end
   end

endmodule
